ip_rx_parse: RTL
================

Name: ip_rx_parse

Overview:
- IPv4 receive stage that feeds the UDP receive stage directly.
- Consumes a 32-bit word stream from the MAC receive stage. Ethernet header is already stripped; word 0 is IPv4 header word 0, big-endian, byte 0 in [31:24].
- Validates the header, strips it including options, and trims Ethernet padding using Total Length.
- Forwards only the UDP datagram (UDP header + payload) with correct last-word byte enables; drops non-matching packets.

Parameters:
- DROP_CNT_W, 16, width of the drop and error counters.
- ACCEPT_BCAST, 1, when 1 also accept destination 255.255.255.255.

Ports:
- clk_user_i  in  1  single clock
- reset_i  in  1  asynchronous active-high reset
- rx_mac_data_vld_i  in  1  input word valid
- rx_mac_data_i  in  32  input word
- rx_mac_be_i  in  4  input byte enables on last word (1111/1110/1100/1000)
- rx_mac_tlast_i  in  1  last word of frame
- rx_mac_ready_o  out  1  input accept
- rx_ip_data_vld_o  out  1  output word valid
- rx_ip_data_o  out  32  output word
- rx_ip_be_o  out  4  output byte enables, valid with tlast
- rx_ip_tlast_o  out  1  last datagram word
- rx_ip_ready_i  in  1  downstream accept
- our_ip_address  in  32  local IPv4 address
- rx_src_ip_o  out  32  source IP of the current/last accepted packet
- drop_cnt_o  out  DROP_CNT_W  packets dropped (saturating)
- err_cnt_o  out  DROP_CNT_W  truncated packets (saturating)

Behaviour:
- Reset is asynchronous on reset_i high. All outputs go to 0, including rx_mac_ready_o and the counters. State goes to HDR.
- A reset mid-packet abandons the packet. The rest of that frame after reset is treated as a new header, so upstream must also be reset.
- Input transfer occurs when rx_mac_data_vld_i & rx_mac_ready_o. Output transfer occurs when rx_ip_data_vld_o & rx_ip_ready_i.
- Output uses a one-deep register slice:
  - rx_mac_ready_o = 1 in HDR and DISCARD.
  - rx_mac_ready_o = (~rx_ip_data_vld_o | rx_ip_ready_i) in PAYLOAD.
  - Output holds stable while vld=1 and ready=0.
- Latency: first payload word appears 1 cycle after its input transfer.
- HDR state:
  - Word counter hcnt counts 0..IHL-1.
  - Word 0 captures version, IHL and Total Length. Word 2 captures protocol. Word 3 captures source IP. Word 4 captures destination IP.
  - Header words are accumulated into a 1's-complement checksum (see Optional Feature).
  - At the last header word, the packet is accepted when all of these hold:
    - version==4
    - IHL>=5
    - TotalLen >= IHL*4+8
    - protocol==17
    - dest==our_ip_address, or (ACCEPT_BCAST and dest==FFFFFFFF)
    - checksum passes
  - Accepted: go to PAYLOAD, load rem = TotalLen - IHL*4 (16 bit), update rx_src_ip_o.
  - Rejected: drop_cnt+1. Go to DISCARD, or to HDR if that word had tlast.
  - tlast during HDR: drop_cnt+1, return to HDR, no output.
- PAYLOAD state:
  - Each input word is forwarded.
  - rem decrements by 4, floored at 0.
  - Final word occurs when rem<=4. Output tlast=1 and be = {1111, 1000, 1100, 1110} for rem[1:0] = {0, 1, 2, 3}.
  - Final word and input tlast together: go to HDR.
  - Final word without input tlast (Ethernet padding): go to DISCARD.
  - Input tlast before the final word (truncated): forward the word with tlast=1 and be=rx_mac_be_i, err_cnt+1, go to HDR.
- DISCARD state: accept and drop words until input tlast, then go to HDR.
- Counters saturate at all-ones.

Optional Feature:
- Macro: IP_RX_CHECKSUM_EN.
- Defined:
  - Accumulate a 16-bit end-around-carry sum over both halves of every header word, including options.
  - The checksum passes iff the final sum == 16'hFFFF.
  - Adds one adder stage, with no extra latency because the verdict is evaluated on the last header word using a combinational final fold.
- Undefined: the checksum is not computed and always passes.

Decomposition:
- Package ip_rx_pkg:
  - State enum: HDR, PAYLOAD, DISCARD.
  - IP_PROTO_UDP=17, IP_VERSION_4=4, IP_BCAST=32'hFFFFFFFF.
  - Function rem_to_be(rem[1:0]).
- Sub-module ip_csum_acc: clear/accumulate of one 32-bit word per cycle; outputs the folded 16-bit sum.

Test Plan:
- IHL=5, TotalLen=40 (20B UDP), dest=our_ip, correct checksum -> 5 output words. First word is the UDP header. Last word has tlast=1, be=1111. drop_cnt=0.
- TotalLen=31 (11B UDP), frame padded to 60B -> 3 words out. Last has be=1110, tlast=1. Padding discarded. Next frame accepted normally.
- IHL=6 with 1 option word, TotalLen=33 -> option word skipped, 3 words out, last be=1000.
- Protocol=6, or dest=our_ip+1 -> no output, drop_cnt=1. Broadcast dest with ACCEPT_BCAST=1 -> accepted.
- Corrupted checksum byte with IP_RX_CHECKSUM_EN -> dropped, drop_cnt=1. Without the macro -> forwarded.
- rx_ip_ready_i toggling 1010… during payload -> no word lost or duplicated, output stable while stalled. Input tlast at payload word 2 of 5 -> tlast out on that word, err_cnt=1.

Source files
------------

// File: rtl/ip_rx_pkg.sv
// Shared types and constants for the IPv4 receive parser.
// FSM states, protocol constants and the last-word byte-enable mapping.
package ip_rx_pkg;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [3:0]  IP_VERSION_4 = 4'd4;
    localparam logic [31:0] IP_BCAST     = 32'hFFFF_FFFF;
    localparam logic [3:0]  IP_IHL_MIN   = 4'd5;

    // Byte enables of the final datagram word from the low bits of the
    // remaining byte count (0 means a full word is left).
    function automatic logic [3:0] rem_to_be(input logic [1:0] rem);
        logic [3:0] be;
        case (rem)
            2'd0:    be = 4'b1111;
            2'd1:    be = 4'b1000;
            2'd2:    be = 4'b1100;
            default: be = 4'b1110;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// IPv4 header checksum accumulator.
// Adds both 16-bit halves of one 32-bit word per cycle into a 16-bit
// end-around-carry sum. sum_o already includes the word on the input, so the
// verdict for the last header word is available in the same cycle.
// Only instantiated when IP_RX_CHECKSUM_EN is defined.
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        acc_en,
    input  logic [31:0] word,
    output logic [15:0] sum_o
);

    logic [15:0] acc_p0;
    logic [15:0] base;

    // One's-complement add: the carry out of bit 15 wraps into bit 0.
    // A single wrap suffices because the wrapped sum cannot carry again.
    function automatic logic [15:0] eac_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Folded sum including the current word; clr restarts from zero.
    always_comb begin
        base  = clr ? 16'd0 : acc_p0;
        sum_o = eac_add(eac_add(base, word[31:16]), word[15:0]);
    end

    // Running sum register, advanced once per accepted header word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0 <= 16'd0;
        end else if (acc_en) begin
            acc_p0 <= sum_o;
        end
    end

endmodule

// File: rtl/ip_rx_parse.sv
// IPv4 receive parser: validates the IPv4 header, strips it (options
// included), trims Ethernet padding using Total Length and forwards only the
// UDP datagram through a one-deep output register slice.
// Optional feature macro: IP_RX_CHECKSUM_EN enables header checksum checking;
// without it the checksum always passes.
module ip_rx_parse
    import ip_rx_pkg::*;
#(
    parameter int unsigned DROP_CNT_W   = 16,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic                  clk_user_i,
    input  logic                  reset_i,
    input  logic                  rx_mac_data_vld_i,
    input  logic [31:0]           rx_mac_data_i,
    input  logic [3:0]            rx_mac_be_i,
    input  logic                  rx_mac_tlast_i,
    output logic                  rx_mac_ready_o,
    output logic                  rx_ip_data_vld_o,
    output logic [31:0]           rx_ip_data_o,
    output logic [3:0]            rx_ip_be_o,
    output logic                  rx_ip_tlast_o,
    input  logic                  rx_ip_ready_i,
    input  logic [31:0]           our_ip_address,
    output logic [31:0]           rx_src_ip_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    output logic [DROP_CNT_W-1:0] err_cnt_o
);

    state_t      state, state_nxt;
    logic        run_r;
    logic [3:0]  hcnt;
    logic [3:0]  ver_r, ihl_r;
    logic [15:0] tot_len_r;
    logic [7:0]  proto_r;
    logic [31:0] src_r, dst_r;
    logic [15:0] rem_r;

    logic        in_xfer, hdr_xfer;
    logic [3:0]  cur_ver, cur_ihl, hdr_words;
    logic [15:0] cur_len, ihl_bytes;
    logic [16:0] len_min;
    logic [7:0]  cur_proto;
    logic [31:0] cur_dst;
    logic        hdr_last, dst_ok, hdr_ok, csum_ok, pay_final;
    logic        accept, drop_inc, err_inc, pay_load;

    // Saturating increment for the drop/error counters.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Held low until the first clock after reset so the upstream sees no
    // accept while reset is asserted.
    assign rx_mac_ready_o = run_r & ((state != PAYLOAD) | ~rx_ip_data_vld_o | rx_ip_ready_i);
    assign in_xfer        = rx_mac_data_vld_i & rx_mac_ready_o;
    assign hdr_xfer       = in_xfer & (state == HDR);

`ifdef IP_RX_CHECKSUM_EN
    logic [15:0] csum_sum;

    ip_csum_acc u_csum (
        .clk    (clk_user_i),
        .rst    (reset_i),
        .clr    (hcnt == 4'd0),
        .acc_en (hdr_xfer),
        .word   (rx_mac_data_i),
        .sum_o  (csum_sum)
    );

    assign csum_ok = (csum_sum == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    // Header fields as seen on the current word: take the live input on the
    // word that carries a field, the captured copy afterwards.
    always_comb begin
        cur_ver   = (hcnt == 4'd0) ? rx_mac_data_i[31:28] : ver_r;
        cur_ihl   = (hcnt == 4'd0) ? rx_mac_data_i[27:24] : ihl_r;
        cur_len   = (hcnt == 4'd0) ? rx_mac_data_i[15:0]  : tot_len_r;
        cur_proto = (hcnt == 4'd2) ? rx_mac_data_i[23:16] : proto_r;
        cur_dst   = (hcnt == 4'd4) ? rx_mac_data_i        : dst_r;
        // A bogus IHL below 5 still consumes the fixed 5-word header so that
        // every field is seen before the verdict.
        hdr_words = (cur_ihl < IP_IHL_MIN) ? IP_IHL_MIN : cur_ihl;
        hdr_last  = (hcnt == hdr_words - 4'd1);
        ihl_bytes = {10'd0, cur_ihl, 2'b00};
        len_min   = {1'b0, ihl_bytes} + 17'd8;
        dst_ok    = (cur_dst == our_ip_address) || (ACCEPT_BCAST && (cur_dst == IP_BCAST));
        hdr_ok    = (cur_ver == IP_VERSION_4) && (cur_ihl >= IP_IHL_MIN) &&
                    ({1'b0, cur_len} >= len_min) && (cur_proto == IP_PROTO_UDP) &&
                    dst_ok && csum_ok;
        pay_final = (rem_r <= 16'd4);
    end

    // FSM state register.
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            state <= HDR;
            run_r <= 1'b0;
        end else begin
            state <= state_nxt;
            run_r <= 1'b1;
        end
    end

    // Next state and per-word control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        pay_load  = 1'b0;
        case (state)
            HDR: begin
                if (in_xfer) begin
                    if (rx_mac_tlast_i) begin
                        drop_inc  = 1'b1;
                        state_nxt = HDR;
                    end else if (hdr_last) begin
                        if (hdr_ok) begin
                            accept    = 1'b1;
                            state_nxt = PAYLOAD;
                        end else begin
                            drop_inc  = 1'b1;
                            state_nxt = DISCARD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (in_xfer) begin
                    pay_load = 1'b1;
                    if (pay_final) begin
                        state_nxt = rx_mac_tlast_i ? HDR : DISCARD;
                    end else if (rx_mac_tlast_i) begin
                        err_inc   = 1'b1;
                        state_nxt = HDR;
                    end
                end
            end
            DISCARD: begin
                if (in_xfer && rx_mac_tlast_i) begin
                    state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    // Header word counter, restarted at the end of every header.
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            hcnt <= 4'd0;
        end else if (hdr_xfer) begin
            hcnt <= (rx_mac_tlast_i || hdr_last) ? 4'd0 : hcnt + 4'd1;
        end
    end

    // Header field capture and remaining-datagram byte count.
    always_ff @(posedge clk_user_i) begin
        if (hdr_xfer) begin
            if (hcnt == 4'd0) begin
                ver_r     <= rx_mac_data_i[31:28];
                ihl_r     <= rx_mac_data_i[27:24];
                tot_len_r <= rx_mac_data_i[15:0];
            end
            if (hcnt == 4'd2) proto_r <= rx_mac_data_i[23:16];
            if (hcnt == 4'd3) src_r   <= rx_mac_data_i;
            if (hcnt == 4'd4) dst_r   <= rx_mac_data_i;
        end
        if (accept) begin
            rem_r <= cur_len - ihl_bytes;
        end else if (pay_load) begin
            rem_r <= (rem_r > 16'd4) ? rem_r - 16'd4 : 16'd0;
        end
    end

    // Output register slice, source address and saturating counters.
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            rx_ip_data_vld_o <= 1'b0;
            rx_ip_data_o     <= 32'd0;
            rx_ip_be_o       <= 4'd0;
            rx_ip_tlast_o    <= 1'b0;
            rx_src_ip_o      <= 32'd0;
            drop_cnt_o       <= '0;
            err_cnt_o        <= '0;
        end else begin
            if (pay_load) begin
                rx_ip_data_vld_o <= 1'b1;
                rx_ip_data_o     <= rx_mac_data_i;
                if (pay_final) begin
                    rx_ip_tlast_o <= 1'b1;
                    rx_ip_be_o    <= rem_to_be(rem_r[1:0]);
                end else if (rx_mac_tlast_i) begin
                    rx_ip_tlast_o <= 1'b1;
                    rx_ip_be_o    <= rx_mac_be_i;
                end else begin
                    rx_ip_tlast_o <= 1'b0;
                    rx_ip_be_o    <= 4'b1111;
                end
            end else if (rx_ip_ready_i) begin
                rx_ip_data_vld_o <= 1'b0;
            end
            if (accept)   rx_src_ip_o <= src_r;
            if (drop_inc) drop_cnt_o  <= sat_inc(drop_cnt_o);
            if (err_inc)  err_cnt_o   <= sat_inc(err_cnt_o);
        end
    end

endmodule
